// File: rtl/freq_sel_ctrl.sv
// freq_sel_ctrl: button-driven speed selector feeding a programmable
// half-period divider. btn3 steps faster, btn2 steps slower; both buttons
// are synchronised and debounced before edge detection. The four speed
// levels map to half-periods HP0..HP3, and run gates the square-wave output.
module freq_sel_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int HP0        = 8,
    parameter int HP1        = 4,
    parameter int HP2        = 2,
    parameter int HP3        = 1,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn3,
    input  logic       btn2,
    input  logic       run,
    output logic       freq,
    output logic [1:0] level,
    output logic       lvl_chg
);

    // Counter only needs to reach DEB_CYCLES-1 before the debounced level flips.
    localparam int DC_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        L0 = 2'd0,
        L1 = 2'd1,
        L2 = 2'd2,
        L3 = 2'd3
    } lvl_t;

    logic            btn3_p0, btn3_p1;
    logic            btn2_p0, btn2_p1;
    logic            db3, db2;
    logic            db3_q, db2_q;
    logic [DC_W-1:0] dc3, dc2;
    logic            press3, press2;
    lvl_t            lvl_q, lvl_d;
    logic            lvl_chg_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hp_last;

    // Terminal count of the divider for a level: half-period minus one.
    function automatic logic [CNT_W-1:0] half_period_last(input lvl_t l);
        case (l)
            L0:      return CNT_W'(HP0 - 1);
            L1:      return CNT_W'(HP1 - 1);
            L2:      return CNT_W'(HP2 - 1);
            default: return CNT_W'(HP3 - 1);
        endcase
    endfunction

    // Two-flop synchronisers plus one-cycle delay of the debounced levels for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn3_p0 <= 1'b0;
            btn3_p1 <= 1'b0;
            btn2_p0 <= 1'b0;
            btn2_p1 <= 1'b0;
            db3_q   <= 1'b0;
            db2_q   <= 1'b0;
        end else begin
            btn3_p0 <= btn3;
            btn3_p1 <= btn3_p0;
            btn2_p0 <= btn2;
            btn2_p1 <= btn2_p0;
            db3_q   <= db3;
            db2_q   <= db2;
        end
    end

    // Debounce btn3: level flips only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            db3 <= 1'b0;
            dc3 <= '0;
        end else if (btn3_p1 == db3) begin
            dc3 <= '0;
        end else if (dc3 == DC_LAST) begin
            db3 <= btn3_p1;
            dc3 <= '0;
        end else begin
            dc3 <= dc3 + 1'b1;
        end
    end

    // Debounce btn2: same filter as btn3.
    always_ff @(posedge clk) begin
        if (reset) begin
            db2 <= 1'b0;
            dc2 <= '0;
        end else if (btn2_p1 == db2) begin
            dc2 <= '0;
        end else if (dc2 == DC_LAST) begin
            db2 <= btn2_p1;
            dc2 <= '0;
        end else begin
            dc2 <= dc2 + 1'b1;
        end
    end

    // Only rising edges of the debounced levels count as presses.
    assign press3 = db3 & ~db3_q;
    assign press2 = db2 & ~db2_q;

    // Level state register; the change pulse is registered on the same edge as the level.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q   <= L0;
            lvl_chg <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            lvl_chg <= lvl_chg_d;
        end
    end

    // Next level: single press steps with saturation, simultaneous presses cancel.
    always_comb begin
        lvl_d = lvl_q;
        if (press3 && !press2) begin
            if (lvl_q != L3) begin
                lvl_d = lvl_t'(lvl_q + 2'd1);
            end
        end else if (press2 && !press3) begin
            if (lvl_q != L0) begin
                lvl_d = lvl_t'(lvl_q - 2'd1);
            end
        end
    end

    // Level-derived controls: change strobe and divider terminal count.
    always_comb begin
        lvl_chg_d = (lvl_d != lvl_q);
        hp_last   = half_period_last(lvl_q);
    end

    assign level = lvl_q;

    // Half-period divider; a level change restarts the phase but keeps freq, run=0 parks it low.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            freq <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            freq <= 1'b0;
        end else if (lvl_chg_d) begin
            cnt  <= '0;
        end else if (cnt == hp_last) begin
            cnt  <= '0;
            freq <= ~freq;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_freq_sel_ctrl.sv
// Directed testbench for freq_sel_ctrl with default parameters
// (DEB_CYCLES=4, HP = 8/4/2/1). Edge k of a scenario is the k-th rising
// clock edge after the stimulus is applied; outputs are sampled 1 time unit
// after each edge.
module tb_freq_sel_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn3 = 1'b0;
    logic       btn2 = 1'b0;
    logic       run = 1'b0;
    logic       freq;
    logic [1:0] level;
    logic       lvl_chg;

    int total = 0;
    int bad   = 0;

    freq_sel_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .btn3    (btn3),
        .btn2    (btn2),
        .run     (run),
        .freq    (freq),
        .level   (level),
        .lvl_chg (lvl_chg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold one or both buttons for 8 edges, release for 10, and count lvl_chg pulses seen.
    task automatic do_press(input bit use3, input bit use2, output int pulses);
        pulses = 0;
        btn3 = use3;
        btn2 = use2;
        repeat (8) begin
            tick();
            if (lvl_chg === 1'b1) pulses++;
        end
        btn3 = 1'b0;
        btn2 = 1'b0;
        repeat (10) begin
            tick();
            if (lvl_chg === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b1;
        repeat (3) tick();
        total++;
        if (level !== 2'd0) begin
            bad++;
            $display("FAIL reset_level: got %0d expected 0", level);
        end
        total++;
        if (freq !== 1'b0) begin
            bad++;
            $display("FAIL reset_freq: got %b expected 0", freq);
        end
        total++;
        if (lvl_chg !== 1'b0) begin
            bad++;
            $display("FAIL reset_lvl_chg: got %b expected 0", lvl_chg);
        end
    endtask

    task automatic test_idle_divider();
        logic exp_f;
        reset = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_f = ((k / 8) % 2) == 1;
            total++;
            if (freq !== exp_f || level !== 2'd0 || lvl_chg !== 1'b0) begin
                bad++;
                $display("FAIL idle_edge%0d: got freq=%b level=%0d lvl_chg=%b expected freq=%b level=0 lvl_chg=0",
                         k, freq, level, lvl_chg, exp_f);
            end
        end
    endtask

    task automatic test_first_press();
        logic [1:0] exp_l;
        logic       exp_c;
        logic       exp_f;
        run = 1'b0;
        tick();
        run  = 1'b1;
        btn3 = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 10) btn3 = 1'b0;
            exp_l = (k >= 7) ? 2'd1 : 2'd0;
            exp_c = (k == 7);
            exp_f = (k >= 11) && (((k - 11) / 4) % 2 == 0);
            total++;
            if (level !== exp_l || lvl_chg !== exp_c || freq !== exp_f) begin
                bad++;
                $display("FAIL press_edge%0d: got level=%0d lvl_chg=%b freq=%b expected level=%0d lvl_chg=%b freq=%b",
                         k, level, lvl_chg, freq, exp_l, exp_c, exp_f);
            end
        end
        repeat (5) tick();
    endtask

    task automatic test_glitch();
        logic       pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] exp_l;
        logic       exp_c;
        // Short pulse of 3 samples must be filtered out.
        btn3 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 3) btn3 = 1'b0;
            total++;
            if (level !== 2'd1 || lvl_chg !== 1'b0) begin
                bad++;
                $display("FAIL short_pulse_edge%0d: got level=%0d lvl_chg=%b expected level=1 lvl_chg=0",
                         k, level, lvl_chg);
            end
        end
        // Pattern 1,1,0,1,1,1,1: the dropout restarts the filter, one increment lands at edge 10.
        for (int k = 1; k <= 20; k++) begin
            btn3 = (k <= 7) ? pat[k-1] : 1'b0;
            tick();
            exp_l = (k >= 10) ? 2'd2 : 2'd1;
            exp_c = (k == 10);
            total++;
            if (level !== exp_l || lvl_chg !== exp_c) begin
                bad++;
                $display("FAIL glitch_edge%0d: got level=%0d lvl_chg=%b expected level=%0d lvl_chg=%b",
                         k, level, lvl_chg, exp_l, exp_c);
            end
        end
    endtask

    task automatic test_saturate();
        int         p;
        logic [1:0] up_lvl [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        int         up_pls [5] = '{1, 1, 1, 0, 0};
        logic [1:0] dn_lvl [5] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
        int         dn_pls [5] = '{1, 1, 1, 0, 0};
        // Bring level from 2 down to 0.
        for (int i = 0; i < 2; i++) do_press(1'b0, 1'b1, p);
        total++;
        if (level !== 2'd0) begin
            bad++;
            $display("FAIL to_level0: got %0d expected 0", level);
        end
        for (int i = 0; i < 5; i++) begin
            do_press(1'b1, 1'b0, p);
            total++;
            if (level !== up_lvl[i] || p != up_pls[i]) begin
                bad++;
                $display("FAIL up_press%0d: got level=%0d pulses=%0d expected level=%0d pulses=%0d",
                         i + 1, level, p, up_lvl[i], up_pls[i]);
            end
        end
        // At level 3 freq toggles on every edge; restart phase via run.
        run = 1'b0;
        tick();
        run = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++;
            if (freq !== logic'(k % 2)) begin
                bad++;
                $display("FAIL hp1_edge%0d: got freq=%b expected %0d", k, freq, k % 2);
            end
        end
        for (int i = 0; i < 5; i++) begin
            do_press(1'b0, 1'b1, p);
            total++;
            if (level !== dn_lvl[i] || p != dn_pls[i]) begin
                bad++;
                $display("FAIL down_press%0d: got level=%0d pulses=%0d expected level=%0d pulses=%0d",
                         i + 1, level, p, dn_lvl[i], dn_pls[i]);
            end
        end
        do_press(1'b1, 1'b0, p);
        total++;
        if (level !== 2'd1 || p != 1) begin
            bad++;
            $display("FAIL back_to_level1: got level=%0d pulses=%0d expected level=1 pulses=1", level, p);
        end
    endtask

    task automatic test_simultaneous();
        int p;
        do_press(1'b1, 1'b1, p);
        total++;
        if (level !== 2'd1 || p != 0) begin
            bad++;
            $display("FAIL both_buttons: got level=%0d pulses=%0d expected level=1 pulses=0", level, p);
        end
    endtask

    task automatic test_run_gate();
        logic exp_f;
        run = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if (freq !== 1'b0) begin
                bad++;
                $display("FAIL run_low_edge%0d: got freq=%b expected 0", k, freq);
            end
        end
        run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_f = ((k / 4) % 2) == 1;
            total++;
            if (freq !== exp_f || level !== 2'd1) begin
                bad++;
                $display("FAIL run_resume_edge%0d: got freq=%b level=%0d expected freq=%b level=1",
                         k, freq, level, exp_f);
            end
        end
    endtask

    task automatic test_reset_mid();
        int         p;
        logic [1:0] exp_l;
        logic       exp_c;
        do_press(1'b1, 1'b0, p);
        total++;
        if (level !== 2'd2) begin
            bad++;
            $display("FAIL pre_reset_level: got %0d expected 2", level);
        end
        tick();
        // Start a debounce, then reset in the middle of it and of the count.
        btn3 = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        total++;
        if (level !== 2'd0 || freq !== 1'b0 || lvl_chg !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got level=%0d freq=%b lvl_chg=%b expected level=0 freq=0 lvl_chg=0",
                     level, freq, lvl_chg);
        end
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_l = (k >= 7) ? 2'd1 : 2'd0;
            exp_c = (k == 7);
            total++;
            if (level !== exp_l || lvl_chg !== exp_c) begin
                bad++;
                $display("FAIL redebounce_edge%0d: got level=%0d lvl_chg=%b expected level=%0d lvl_chg=%b",
                         k, level, lvl_chg, exp_l, exp_c);
            end
        end
        btn3 = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_idle_divider();
        test_first_press();
        test_glitch();
        test_saturate();
        test_simultaneous();
        test_run_gate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
